adc_frame_wr_mc: RTL and testbench
==================================

Name: adc_frame_wr_mc

Overview:
- Parametrised multi-channel successor to the single-channel ADC-to-FIFO write controller.
- Captures one sample beat (NUM_CH samples) per ad_data_valid.
- Serialises each beat into the write FIFO one channel per cycle, tagged with its channel index.
- Enforces frame length, handles ADC over-range per a selectable mode, absorbs FIFO backpressure with a one-beat hold register, and reports drops and frame integrity to the frame controller.

Parameters:
- DATA_W, 8, sample width per channel.
- NUM_CH, 2, channels per beat (1..16).
- FRAME_LEN, 256, beats per complete frame.
- OTR_MODE, 0, over-range handling: 0 = drop beat, 1 = clamp channel to all-ones, 2 = pass through.
- CNT_W, $clog2(FRAME_LEN+1), beat counter width (derived).
- CH_W, max(1,$clog2(NUM_CH)), channel tag width (derived).

Ports:
- wr_clk  in  1  write clock.
- rst_n  in  1  reset.
- frame_start  in  1  one-cycle pulse; starts a frame.
- frame_done  in  1  one-cycle pulse; ends a frame.
- ad_data  in  NUM_CH*DATA_W  beat; channel c at bits [c*DATA_W +: DATA_W].
- ad_data_valid  in  1  beat valid.
- ad_otr  in  NUM_CH  per-channel over-range flag, qualified by ad_data_valid.
- wr_rst_busy  in  1  FIFO reset in progress.
- almost_full  in  1  FIFO almost full.
- full  in  1  FIFO full.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  DATA_W  sample written.
- fifo_wr_ch  out  CH_W  channel tag of fifo_wr_data.
- frame_busy  out  1  frame in progress.
- beat_count  out  CNT_W  beats accepted this frame.
- drop_count  out  16  beats dropped this frame; saturates at 0xFFFF.
- fifo_overflow  out  1  sticky per frame; a beat was lost to backpressure.
- frame_ok  out  1  one-cycle pulse: frame closed with beat_count == FRAME_LEN and no drops.
- frame_error  out  1  sticky until next frame_start.

Behaviour:
- Interface: single clock wr_clk; rst_n asynchronous, active-low.
- Reset: all outputs 0; state IDLE; hold register empty.
- States and transitions:
  - IDLE -> ACTIVE on frame_start when wr_rst_busy = 0.
  - ACTIVE -> CLOSE on frame_done.
  - CLOSE -> IDLE once the in-flight beat and the hold register are written.
  - frame_busy = 1 in ACTIVE and CLOSE.
- Frame start: frame_start (any state, wr_rst_busy = 0) clears beat_count, drop_count, fifo_overflow, frame_error and the hold register, aborts any drain, then enters ACTIVE. It has priority over a simultaneous frame_done or ad_data_valid.
- Beat accept:
  - In ACTIVE, ad_data_valid sampled high with beat_count < FRAME_LEN accepts the beat.
  - beat_count increments at that edge and saturates at FRAME_LEN.
  - Beats beyond FRAME_LEN are ignored; they are not counted as drops.
- Over-range:
  - OTR_MODE 0: beat with any ad_otr bit set is discarded and counted in drop_count; fifo_overflow is not set.
  - OTR_MODE 1: each flagged channel is written as all-ones.
  - OTR_MODE 2: data passes through unchanged.
- Backpressure on accept:
  - If almost_full is high at the accept edge, the beat is dropped: drop_count +1, fifo_overflow = 1.
  - If a drain is in progress and the hold register is empty, the beat goes to the hold register.
  - If the hold register is already full, the beat is dropped and fifo_overflow = 1.
- Drain:
  - An accepted beat sampled at edge k produces fifo_wr_en = 1 for cycles k+1 .. k+NUM_CH, channels 0..NUM_CH-1 in order, with fifo_wr_ch = channel index.
  - Drain is stall-free when full stays low.
  - When full is sampled high, the next write is withheld: fifo_wr_en = 0 and the channel index holds; the drain resumes the cycle after full is sampled low.
  - The hold register drains immediately after the current beat, with no idle cycle.
- System requirement: the FIFO almost_full threshold is at least NUM_CH+2 entries below depth.
- Close:
  - On leaving CLOSE, frame_ok pulses if beat_count == FRAME_LEN and drop_count == 0.
  - Otherwise frame_error = 1.
  - A frame_done outside ACTIVE is ignored.
- wr_rst_busy high:
  - Next cycle: fifo_wr_en = 0, drain aborted, hold register cleared, state IDLE.
  - frame_error = 1 if the frame was ACTIVE or CLOSE.
  - frame_start is ignored while wr_rst_busy is high.
- Counters are unsigned and never wrap.

Test Plan:
- NUM_CH=2, FRAME_LEN=4: frame_start, 4 valid beats spaced 3 cycles, frame_done -> 8 writes, fifo_wr_ch 0,1,0,1…, beat_count 4, frame_ok one pulse, frame_error 0.
- Back-to-back beats every cycle, NUM_CH=2 -> beat 2 goes to the hold register, beat 3 is dropped; drop_count 1, fifo_overflow 1, frame_error 1 at close.
- full high for 3 cycles mid-drain -> fifo_wr_en low for 3 cycles, channel index held, no sample lost or duplicated.
- OTR_MODE 0 / 1 / 2 with ad_otr = 2'b10, ad_data = {8'h12, 8'h34} -> mode 0: no write and drop_count 1; mode 1: writes 8'h34, 8'hFF; mode 2: writes 8'h34, 8'h12.
- 6 beats with FRAME_LEN=4 -> exactly 8 writes, beat_count 4, drop_count 0, frame_ok.
- wr_rst_busy asserted mid-drain -> fifo_wr_en 0 the next cycle, state IDLE, frame_error 1; a following frame_start clears frame_error.

Source files
------------

// File: rtl/adc_frame_wr_mc.sv
// Multi-channel ADC beat capture and serialising FIFO write controller.
// Captures one NUM_CH-sample beat per ad_data_valid, writes it to the FIFO
// one channel per cycle with a channel tag, and reports frame integrity.
module adc_frame_wr_mc #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned OTR_MODE  = 0,
    parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1),
    parameter int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     wr_clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic                     frame_done,
    input  logic [NUM_CH*DATA_W-1:0] ad_data,
    input  logic                     ad_data_valid,
    input  logic [NUM_CH-1:0]        ad_otr,
    input  logic                     wr_rst_busy,
    input  logic                     almost_full,
    input  logic                     full,
    output logic                     fifo_wr_en,
    output logic [DATA_W-1:0]        fifo_wr_data,
    output logic [CH_W-1:0]          fifo_wr_ch,
    output logic                     frame_busy,
    output logic [CNT_W-1:0]         beat_count,
    output logic [15:0]              drop_count,
    output logic                     fifo_overflow,
    output logic                     frame_ok,
    output logic                     frame_error
);

    localparam int unsigned BEAT_W = NUM_CH * DATA_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_CLOSE  = 2'd2;

    logic [1:0]        state,     state_d;
    logic [BEAT_W-1:0] cur_data,  cur_data_d;
    logic              cur_pend,  cur_pend_d;
    logic [CH_W-1:0]   cur_ch,    cur_ch_d;
    logic [BEAT_W-1:0] hold_data, hold_data_d;
    logic              hold_vld,  hold_vld_d;

    logic              wr_en_d;
    logic [DATA_W-1:0] wr_data_d;
    logic [CH_W-1:0]   wr_ch_d;
    logic [CNT_W-1:0]  beat_cnt_d;
    logic [15:0]       drop_cnt_d;
    logic              ovf_d;
    logic              ok_d;
    logic              err_d;

    logic [BEAT_W-1:0] beat_capt;
    logic              accept;
    logic              take_new;
    logic              to_hold;
    logic              emit;
    logic [BEAT_W-1:0] src;
    logic [CH_W-1:0]   src_ch;

    // Over-range clamp applied to the incoming beat before it is stored.
    always_comb begin
        beat_capt = ad_data;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (OTR_MODE == 1 && ad_otr[c]) begin
                beat_capt[c*DATA_W +: DATA_W] = '1;
            end
        end
    end

    assign accept = (state == S_ACTIVE) && ad_data_valid && (beat_count < CNT_W'(FRAME_LEN));

    // Next-state, drain sequencing, counters and status.
    always_comb begin
        state_d     = state;
        cur_data_d  = cur_data;
        cur_pend_d  = cur_pend;
        cur_ch_d    = cur_ch;
        hold_data_d = hold_data;
        hold_vld_d  = hold_vld;
        wr_en_d     = 1'b0;
        wr_data_d   = fifo_wr_data;
        wr_ch_d     = fifo_wr_ch;
        beat_cnt_d  = beat_count;
        drop_cnt_d  = drop_count;
        ovf_d       = fifo_overflow;
        ok_d        = 1'b0;
        err_d       = frame_error;
        take_new    = 1'b0;
        to_hold     = 1'b0;
        emit        = 1'b0;
        src         = cur_data;
        src_ch      = cur_ch;

        if (wr_rst_busy) begin
            state_d    = S_IDLE;
            cur_pend_d = 1'b0;
            cur_ch_d   = '0;
            hold_vld_d = 1'b0;
            if (state != S_IDLE) begin
                err_d = 1'b1;
            end
        end else if (frame_start) begin
            state_d    = S_ACTIVE;
            cur_pend_d = 1'b0;
            cur_ch_d   = '0;
            hold_vld_d = 1'b0;
            beat_cnt_d = '0;
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
            err_d      = 1'b0;
        end else begin
            // Route an accepted beat: discard, hold, or start draining it.
            if (accept) begin
                beat_cnt_d = beat_count + CNT_W'(1);
                if (OTR_MODE == 0 && (|ad_otr)) begin
                    if (drop_count != 16'hFFFF) drop_cnt_d = drop_count + 16'd1;
                end else if (almost_full || hold_vld) begin
                    if (drop_count != 16'hFFFF) drop_cnt_d = drop_count + 16'd1;
                    ovf_d = 1'b1;
                end else if (cur_pend) begin
                    to_hold = 1'b1;
                end else begin
                    take_new = 1'b1;
                end
            end

            // Drain: continue the current beat, else start the held or new one.
            if (cur_pend) begin
                if (!full) begin
                    emit = 1'b1;
                    if (cur_ch == CH_W'(NUM_CH - 1)) begin
                        cur_ch_d = '0;
                        if (hold_vld) begin
                            cur_data_d = hold_data;
                            hold_vld_d = 1'b0;
                        end else begin
                            cur_pend_d = 1'b0;
                        end
                    end else begin
                        cur_ch_d = cur_ch + CH_W'(1);
                    end
                end
            end else if (hold_vld || take_new) begin
                src        = hold_vld ? hold_data : beat_capt;
                src_ch     = '0;
                cur_data_d = src;
                hold_vld_d = 1'b0;
                cur_pend_d = 1'b1;
                cur_ch_d   = '0;
                if (!full) begin
                    emit = 1'b1;
                    if (NUM_CH == 1) begin
                        cur_pend_d = 1'b0;
                    end else begin
                        cur_ch_d = CH_W'(1);
                    end
                end
            end

            if (to_hold) begin
                hold_data_d = beat_capt;
                hold_vld_d  = 1'b1;
            end

            if (emit) begin
                wr_en_d   = 1'b1;
                wr_data_d = src[src_ch*DATA_W +: DATA_W];
                wr_ch_d   = src_ch;
            end

            case (state)
                S_ACTIVE: begin
                    if (frame_done) state_d = S_CLOSE;
                end
                S_CLOSE: begin
                    if (!cur_pend && !hold_vld) begin
                        state_d = S_IDLE;
                        if (beat_count == CNT_W'(FRAME_LEN) && drop_count == 16'd0) begin
                            ok_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: state_d = state;
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cur_data      <= '0;
            cur_pend      <= 1'b0;
            cur_ch        <= '0;
            hold_data     <= '0;
            hold_vld      <= 1'b0;
            fifo_wr_en    <= 1'b0;
            fifo_wr_data  <= '0;
            fifo_wr_ch    <= '0;
            frame_busy    <= 1'b0;
            beat_count    <= '0;
            drop_count    <= '0;
            fifo_overflow <= 1'b0;
            frame_ok      <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            state         <= state_d;
            cur_data      <= cur_data_d;
            cur_pend      <= cur_pend_d;
            cur_ch        <= cur_ch_d;
            hold_data     <= hold_data_d;
            hold_vld      <= hold_vld_d;
            fifo_wr_en    <= wr_en_d;
            fifo_wr_data  <= wr_data_d;
            fifo_wr_ch    <= wr_ch_d;
            frame_busy    <= (state_d == S_ACTIVE) || (state_d == S_CLOSE);
            beat_count    <= beat_cnt_d;
            drop_count    <= drop_cnt_d;
            fifo_overflow <= ovf_d;
            frame_ok      <= ok_d;
            frame_error   <= err_d;
        end
    end

endmodule

// File: tb/tb_adc_frame_wr_mc.sv
// Directed bench for adc_frame_wr_mc: three instances (OTR_MODE 0/1/2)
// share NUM_CH=2, FRAME_LEN=4 stimulus; instance 0 carries most checks.
module tb_adc_frame_wr_mc;

    localparam int unsigned DW = 8;
    localparam int unsigned NC = 2;
    localparam int unsigned FL = 4;

    logic        wr_clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        frame_done;
    logic [15:0] ad_data;
    logic        ad_data_valid;
    logic [1:0]  ad_otr;
    logic        wr_rst_busy;
    logic        almost_full;
    logic        full;

    logic        wr_en   [3];
    logic [7:0]  wr_data [3];
    logic [0:0]  wr_ch   [3];
    logic        busy    [3];
    logic [2:0]  bcnt    [3];
    logic [15:0] dcnt    [3];
    logic        ovf     [3];
    logic        ok      [3];
    logic        err     [3];

    logic [8:0] wq0[$];
    logic [8:0] wq1[$];
    logic [8:0] wq2[$];
    int ok_cnt0;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 wr_clk = ~wr_clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        adc_frame_wr_mc #(
            .DATA_W(DW), .NUM_CH(NC), .FRAME_LEN(FL), .OTR_MODE(g)
        ) u_dut (
            .wr_clk       (wr_clk),
            .rst_n        (rst_n),
            .frame_start  (frame_start),
            .frame_done   (frame_done),
            .ad_data      (ad_data),
            .ad_data_valid(ad_data_valid),
            .ad_otr       (ad_otr),
            .wr_rst_busy  (wr_rst_busy),
            .almost_full  (almost_full),
            .full         (full),
            .fifo_wr_en   (wr_en[g]),
            .fifo_wr_data (wr_data[g]),
            .fifo_wr_ch   (wr_ch[g]),
            .frame_busy   (busy[g]),
            .beat_count   (bcnt[g]),
            .drop_count   (dcnt[g]),
            .fifo_overflow(ovf[g]),
            .frame_ok     (ok[g]),
            .frame_error  (err[g])
        );
    end

    // Log FIFO writes and frame_ok pulses on the falling edge.
    always @(negedge wr_clk) begin
        if (wr_en[0]) wq0.push_back({wr_ch[0], wr_data[0]});
        if (wr_en[1]) wq1.push_back({wr_ch[1], wr_data[1]});
        if (wr_en[2]) wq2.push_back({wr_ch[2], wr_data[2]});
        if (ok[0]) ok_cnt0++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge wr_clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        wq0.delete();
        wq1.delete();
        wq2.delete();
        ok_cnt0 = 0;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic pulse_done();
        frame_done = 1'b1;
        tick(1);
        frame_done = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] d, input logic [1:0] o);
        ad_data       = d;
        ad_otr        = o;
        ad_data_valid = 1'b1;
        tick(1);
        ad_data_valid = 1'b0;
        ad_otr        = 2'b00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        frame_start = 1'b0; frame_done = 1'b0; ad_data = '0; ad_data_valid = 1'b0;
        ad_otr = '0; wr_rst_busy = 1'b0; almost_full = 1'b0; full = 1'b0;
        tick(3);
        tests_run++;
        if (wr_en[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en: got %0b, expected 0", wr_en[0]); end
        tests_run++;
        if (busy[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b, expected 0", busy[0]); end
        tests_run++;
        if (bcnt[0] !== 3'd0) begin tests_failed++; $display("FAIL reset_beat_count: got %0d, expected 0", bcnt[0]); end
        tests_run++;
        if (dcnt[0] !== 16'd0) begin tests_failed++; $display("FAIL reset_drop_count: got %0d, expected 0", dcnt[0]); end
        tests_run++;
        if ({ovf[0], ok[0], err[0]} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_flags: got %b, expected 000", {ovf[0], ok[0], err[0]});
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_basic();
        logic [8:0] exp_q [8];
        exp_q = '{9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1, 9'h0C0, 9'h1C1, 9'h0D0, 9'h1D1};
        clear_logs();
        pulse_start();
        send_beat(16'hA1A0, 2'b00);
        tests_run++;
        if ({wr_en[0], wr_ch[0], wr_data[0]} !== {1'b1, 1'b0, 8'hA0}) begin
            tests_failed++; $display("FAIL basic_first_write: got %h, expected %h", {wr_en[0], wr_ch[0], wr_data[0]}, {1'b1, 1'b0, 8'hA0});
        end
        tests_run++;
        if (busy[0] !== 1'b1) begin tests_failed++; $display("FAIL basic_busy: got %0b, expected 1", busy[0]); end
        tick(2);
        send_beat(16'hB1B0, 2'b00); tick(2);
        send_beat(16'hC1C0, 2'b00); tick(2);
        send_beat(16'hD1D0, 2'b00); tick(2);
        pulse_done();
        tick(4);
        tests_run++;
        if (wq0.size() !== 8) begin tests_failed++; $display("FAIL basic_write_count: got %0d, expected 8", wq0.size()); end
        for (int i = 0; i < 8; i++) begin
            logic [8:0] got;
            got = (i < wq0.size()) ? wq0[i] : 9'h1FF;
            tests_run++;
            if (got !== exp_q[i]) begin tests_failed++; $display("FAIL basic_write[%0d]: got %h, expected %h", i, got, exp_q[i]); end
        end
        tests_run++;
        if (bcnt[0] !== 3'd4) begin tests_failed++; $display("FAIL basic_beat_count: got %0d, expected 4", bcnt[0]); end
        tests_run++;
        if (ok_cnt0 !== 1) begin tests_failed++; $display("FAIL basic_frame_ok: got %0d pulses, expected 1", ok_cnt0); end
        tests_run++;
        if ({err[0], busy[0]} !== 2'b00) begin tests_failed++; $display("FAIL basic_close: got err/busy %b, expected 00", {err[0], busy[0]}); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_q [6];
        logic [15:0] beats [4];
        exp_q = '{9'h020, 9'h121, 9'h030, 9'h131, 9'h050, 9'h151};
        beats = '{16'h2120, 16'h3130, 16'h4140, 16'h5150};
        clear_logs();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            ad_data = beats[i];
            ad_data_valid = 1'b1;
            tick(1);
        end
        ad_data_valid = 1'b0;
        tick(4);
        pulse_done();
        tick(4);
        tests_run++;
        if (wq0.size() !== 6) begin tests_failed++; $display("FAIL b2b_write_count: got %0d, expected 6", wq0.size()); end
        for (int i = 0; i < 6; i++) begin
            logic [8:0] got;
            got = (i < wq0.size()) ? wq0[i] : 9'h1FF;
            tests_run++;
            if (got !== exp_q[i]) begin tests_failed++; $display("FAIL b2b_write[%0d]: got %h, expected %h", i, got, exp_q[i]); end
        end
        tests_run++;
        if (dcnt[0] !== 16'd1) begin tests_failed++; $display("FAIL b2b_drop_count: got %0d, expected 1", dcnt[0]); end
        tests_run++;
        if (ovf[0] !== 1'b1) begin tests_failed++; $display("FAIL b2b_overflow: got %0b, expected 1", ovf[0]); end
        tests_run++;
        if ({err[0], ok_cnt0[0]} !== 2'b10) begin tests_failed++; $display("FAIL b2b_close: got err/ok %b, expected 10", {err[0], ok_cnt0[0]}); end
    endtask

    task automatic test_full_stall();
        logic [8:0] exp_q [4];
        exp_q = '{9'h060, 9'h161, 9'h070, 9'h171};
        clear_logs();
        pulse_start();
        send_beat(16'h6160, 2'b00);
        full = 1'b1;
        tick(1);
        tests_run++;
        if ({wr_en[0], wr_ch[0]} !== 2'b00) begin tests_failed++; $display("FAIL stall_cycle1: got en/ch %b, expected 00", {wr_en[0], wr_ch[0]}); end
        send_beat(16'h7170, 2'b00);
        tests_run++;
        if ({wr_en[0], wr_ch[0]} !== 2'b00) begin tests_failed++; $display("FAIL stall_cycle2: got en/ch %b, expected 00", {wr_en[0], wr_ch[0]}); end
        tick(1);
        tests_run++;
        if ({wr_en[0], wr_ch[0]} !== 2'b00) begin tests_failed++; $display("FAIL stall_cycle3: got en/ch %b, expected 00", {wr_en[0], wr_ch[0]}); end
        full = 1'b0;
        tick(1);
        tests_run++;
        if ({wr_en[0], wr_ch[0], wr_data[0]} !== {1'b1, 1'b1, 8'h61}) begin
            tests_failed++; $display("FAIL stall_resume: got %h, expected %h", {wr_en[0], wr_ch[0], wr_data[0]}, {1'b1, 1'b1, 8'h61});
        end
        tick(4);
        pulse_done();
        tick(3);
        tests_run++;
        if (wq0.size() !== 4) begin tests_failed++; $display("FAIL stall_write_count: got %0d, expected 4", wq0.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [8:0] got;
            got = (i < wq0.size()) ? wq0[i] : 9'h1FF;
            tests_run++;
            if (got !== exp_q[i]) begin tests_failed++; $display("FAIL stall_write[%0d]: got %h, expected %h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_otr();
        clear_logs();
        pulse_start();
        send_beat(16'h1234, 2'b10);
        tick(3);
        tests_run++;
        if (wq0.size() !== 0) begin tests_failed++; $display("FAIL otr0_writes: got %0d, expected 0", wq0.size()); end
        tests_run++;
        if ({dcnt[0], ovf[0]} !== {16'd1, 1'b0}) begin
            tests_failed++; $display("FAIL otr0_drop: got drop %0d ovf %0b, expected drop 1 ovf 0", dcnt[0], ovf[0]);
        end
        tests_run++;
        if (wq1.size() !== 2 || wq1[0] !== 9'h034 || wq1[1] !== 9'h1FF) begin
            tests_failed++; $display("FAIL otr1_writes: got %0d writes (%p), expected 034 1ff", wq1.size(), wq1);
        end
        tests_run++;
        if (dcnt[1] !== 16'd0) begin tests_failed++; $display("FAIL otr1_drop: got %0d, expected 0", dcnt[1]); end
        tests_run++;
        if (wq2.size() !== 2 || wq2[0] !== 9'h034 || wq2[1] !== 9'h112) begin
            tests_failed++; $display("FAIL otr2_writes: got %0d writes (%p), expected 034 112", wq2.size(), wq2);
        end
    endtask

    task automatic test_overlength();
        clear_logs();
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            send_beat(16'h0101 * 16'(i + 1), 2'b00);
            tick(2);
        end
        pulse_done();
        tick(4);
        tests_run++;
        if (wq0.size() !== 8) begin tests_failed++; $display("FAIL ovl_write_count: got %0d, expected 8", wq0.size()); end
        tests_run++;
        if (bcnt[0] !== 3'd4) begin tests_failed++; $display("FAIL ovl_beat_count: got %0d, expected 4", bcnt[0]); end
        tests_run++;
        if (dcnt[0] !== 16'd0) begin tests_failed++; $display("FAIL ovl_drop_count: got %0d, expected 0", dcnt[0]); end
        tests_run++;
        if (ok_cnt0 !== 1) begin tests_failed++; $display("FAIL ovl_frame_ok: got %0d pulses, expected 1", ok_cnt0); end
    endtask

    task automatic test_rst_busy();
        clear_logs();
        pulse_start();
        send_beat(16'h9190, 2'b00);
        wr_rst_busy = 1'b1;
        tick(1);
        tests_run++;
        if (wr_en[0] !== 1'b0) begin tests_failed++; $display("FAIL rstb_wr_en: got %0b, expected 0", wr_en[0]); end
        tests_run++;
        if ({busy[0], err[0]} !== 2'b01) begin tests_failed++; $display("FAIL rstb_state: got busy/err %b, expected 01", {busy[0], err[0]}); end
        pulse_start();
        tests_run++;
        if (busy[0] !== 1'b0) begin tests_failed++; $display("FAIL rstb_start_ignored: got busy %0b, expected 0", busy[0]); end
        wr_rst_busy = 1'b0;
        tick(2);
        tests_run++;
        if (wq0.size() !== 1) begin tests_failed++; $display("FAIL rstb_write_count: got %0d, expected 1", wq0.size()); end
        pulse_start();
        tests_run++;
        if ({busy[0], err[0]} !== 2'b10) begin tests_failed++; $display("FAIL rstb_restart: got busy/err %b, expected 10", {busy[0], err[0]}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_full_stall();
        test_otr();
        test_overlength();
        test_rst_busy();
        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
